// File: rtl/mac_pkg.sv
// Types and constants shared by the MAC datapath blocks.
package mac_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int MAC_WIDTH = 8;

endpackage

// File: rtl/mac_bit_counter.sv
// Bit-position counter for the serializer; term flags the last bit of a word.
module mac_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  // clr wins over inc so a word end and the next load restart at bit 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign term = (cnt == CNT_MAX);

endmodule

// File: rtl/mac_bit_serializer.sv
// Parallel-in, LSB-first serial-out reader with valid/ready on both sides.
//
// state | meaning
// IDLE  | no word held; in_ready high, waiting for in_valid
// SHIFT | word held; presenting shreg[0] until the last bit transfers
module mac_bit_serializer
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init0,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             last,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             term;
  logic             load;
  logic             xfer;
  logic             cnt_clr;
  logic             cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    bit_valid = 1'b0;
    busy      = 1'b0;
    last      = 1'b0;
    load      = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        load     = in_valid && !init0;
        if (load) state_nxt = SHIFT;
      end
      SHIFT: begin
        bit_valid = 1'b1;
        busy      = 1'b1;
        last      = term;
        // bit_ready reaches in_ready only on the last bit, enabling a bubble-free reload
        in_ready  = term && bit_ready;
        xfer      = bit_ready && !init0;
        load      = xfer && term && in_valid;
        if (xfer && term && !in_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (init0) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (init0) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= in_data;
    end else if (xfer) begin
      shreg <= {1'b0, shreg[WIDTH-1:1]};
    end
  end

  assign bit_out = shreg[0];
  assign cnt_clr = init0 || load || (xfer && term);
  assign cnt_inc = xfer && !term;

  mac_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .term (term)
  );

endmodule

// File: doc/mac_bit_serializer.md
# mac_bit_serializer

- Parallel-in, serial-out reader for the MAC datapath: the unloading counterpart to the team's 1-bit load/hold register cells.
- Accepts a WIDTH-bit word, then delivers it one bit per accepted transfer, LSB first, to a bit-serial consumer such as the shift-add multiplier control.
- Both sides use valid/ready handshakes.
- Back-to-back words stream with zero bubble cycles.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
- init0  input  1  synchronous clear; highest priority of all synchronous inputs.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block accepts in_data on this edge when high.
- bit_out  output  1  current serial bit (LSB first).
- bit_valid  output  1  bit_out is valid.
- bit_ready  input  1  consumer takes bit_out on this edge when high.
- last  output  1  bit_out is bit WIDTH-1 of the current word.
- busy  output  1  a word is held (state SHIFT).

## Operation
State machine states:
- IDLE:
  - in_ready=1, bit_valid=0.
  - in_valid=1 loads shreg <= in_data, cnt <= 0, next state SHIFT.
- SHIFT:
  - bit_valid=1, bit_out=shreg[0], last=(cnt==WIDTH-1).
  - When bit_valid and bit_ready are both high (a bit transfer), shreg shifts right with zero fill and cnt increments.
  - A transfer with last=1 ends the word.

Word end and back-to-back streaming:
- in_ready is also high in SHIFT while last=1 and bit_ready=1.
- If in_valid=1 at that edge: load the new word, cnt <= 0, stay in SHIFT (no bubble).
- Otherwise return to IDLE.

Rules and boundary conditions:
- Outputs are combinational from state/shreg/cnt only; there is no combinational path from in_valid or bit_ready to bit_valid.
- in_ready depends combinationally on bit_ready in the last-bit case only.
- cnt width is $clog2(WIDTH). cnt never exceeds WIDTH-1 and never wraps inside a word.
- bit_ready=0 in SHIFT: shreg, cnt, bit_out and last hold.
- init0=1: next edge forces IDLE, shreg <= 0, cnt <= 0. A simultaneous in_valid or bit_ready is ignored; no load and no transfer occur.
- in_valid while in SHIFT and not at the last bit is ignored (in_ready=0); the producer must hold the word.
- Reset mid-word: the partial word is discarded and no bits resume after reset release.

## Timing
- Reset values (rst=0): state=IDLE, shreg=0, cnt=0.
  - Outputs: in_ready=1, bit_valid=0, bit_out=0, last=0, busy=0.
- Load latency: word accepted at edge N gives bit_valid=1 with bit 0 in the cycle after edge N.
- Throughput: one bit per cycle while bit_ready=1. With continuous input, a word takes exactly WIDTH cycles.
- The end-of-word edge and the next-word load occur on the same edge.
- Deassertion of rst takes effect asynchronously. The first load is possible at the first rising edge with rst=1.

## Structure
- Shared package mac_pkg holds:
  - state enum {IDLE, SHIFT};
  - MAC_WIDTH default constant (8), shared with the multiplier.
- One natural sub-module: mac_bit_counter. It is a $clog2(WIDTH)-bit up-counter with these controls:
  - clr (load/init0);
  - inc (bit transfer);
  - terminal flag (cnt==WIDTH-1), which drives last.
- The top level contains the FSM, the shift register and the handshake logic.

## Test plan
WIDTH=8 throughout.
- Word with bit_ready tied high: reset, then load 8'hA5 → bit_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles; last high only on the 8th; in_ready=1, busy=0 after.
- Backpressure: load 8'h3C and toggle bit_ready 1,0,1,0… → bit_out/last stable while bit_ready=0; sequence 0,0,1,1,1,1,0,0 is delivered in full.
- Back-to-back: in_valid held with 8'h01 then 8'h80 → 16 consecutive bit_valid cycles with no gap; bits 1,0×7 then 0×7,1; last on cycles 8 and 16.
- init0 mid-word: after 3 bits of 8'hFF, init0=1 with bit_ready=1 → next cycle bit_valid=0, in_ready=1. The next load of 8'h0F restarts at bit 0.
- Async reset: rst=0 between edges mid-word → outputs take reset values before the next edge. init0 and in_valid together in IDLE → no load, busy stays 0.
